clock_time_scheduler: RTL

Sequencing controller for the digital-clock datapath. Divides the system clock down to a one-second timebase, keeps the seconds count, and issues the single-cycle `minute_tick` enable that advances the minute counter. It also runs a RUN / SET_MIN / SET_HOUR mode state machine, so two buttons can adjust minutes and hours and the display can blink the field being edited.

---
 rtl/clock_time_scheduler_if.sv | 21 ++
 rtl/clock_time_scheduler.sv | 115 +++++++++++
 2 files changed

// File: rtl/clock_time_scheduler_if.sv
// Button inputs and time/mode outputs of the clock sequencing controller.
// The master drives the buttons; the slave (the scheduler) drives everything else.
interface clock_time_scheduler_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] sec;
  logic       minute_tick;
  logic       hour_inc;
  logic [1:0] mode;
  logic       blink;

  modport master (
    output btn_mode, btn_inc,
    input  sec, minute_tick, hour_inc, mode, blink
  );

  modport slave (
    input  btn_mode, btn_inc,
    output sec, minute_tick, hour_inc, mode, blink
  );
endinterface

// File: rtl/clock_time_scheduler.sv
// One-second timebase, seconds count, minute/hour advance pulses and RUN/SET_MIN/SET_HOUR mode FSM.
// Optional feature macro: CLOCK_SCHED_AUTO_REPEAT_EN (held btn_inc repeats once per second in set modes).
module clock_time_scheduler #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input logic clk,
    input logic reset,
    clock_time_scheduler_if.slave bus
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_MIN  = 2'd1,
        SET_HOUR = 2'd2
    } mode_t;

    mode_t         state;
    logic [PW-1:0] presc;
    logic [5:0]    sec_q;
    logic          mt_q, hi_q, blink_q;

    // bit 0 = btn_mode, bit 1 = btn_inc
    logic [1:0] sync1, sync2, prev;

    logic sec_pulse, mode_edge, inc_edge, inc_fire;

    assign sec_pulse = (presc == PRESC_MAX);
    assign mode_edge = sync2[0] & ~prev[0];
    assign inc_edge  = sync2[1] & ~prev[1];

`ifdef CLOCK_SCHED_AUTO_REPEAT_EN
    logic [1:0] hold;

    // Counts whole seconds of continuous hold; saturates at 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hold <= '0;
        else if (mode_edge || !sync2[1] || state == RUN)
            hold <= '0;
        else if (sec_pulse && hold != 2'd2)
            hold <= hold + 2'd1;
    end

    assign inc_fire = inc_edge | (sec_pulse & sync2[1] & (hold == 2'd2));
`else
    assign inc_fire = inc_edge;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
            presc   <= '0;
            sec_q   <= '0;
            mt_q    <= 1'b0;
            hi_q    <= 1'b0;
            blink_q <= 1'b1;
            state   <= RUN;
        end else begin
            sync1 <= {bus.btn_inc, bus.btn_mode};
            sync2 <= sync1;
            prev  <= sync2;
            mt_q  <= 1'b0;
            hi_q  <= 1'b0;
            presc <= sec_pulse ? '0 : presc + 1'b1;

            if (mode_edge) begin
                // Mode change wins over a coincident inc edge; no pulse this cycle.
                sec_q   <= '0;
                blink_q <= 1'b1;
                unique case (state)
                    RUN:     state <= SET_MIN;
                    SET_MIN: state <= SET_HOUR;
                    default: begin
                        state <= RUN;
                        presc <= '0;
                    end
                endcase
            end else begin
                unique case (state)
                    RUN: begin
                        blink_q <= 1'b1;
                        if (sec_pulse) begin
                            if (sec_q == 6'd59) begin
                                sec_q <= '0;
                                mt_q  <= 1'b1;
                            end else begin
                                sec_q <= sec_q + 6'd1;
                            end
                        end
                    end
                    SET_MIN: begin
                        sec_q <= '0;
                        if (sec_pulse) blink_q <= ~blink_q;
                        mt_q <= inc_fire;
                    end
                    default: begin
                        sec_q <= '0;
                        if (sec_pulse) blink_q <= ~blink_q;
                        hi_q <= inc_fire;
                    end
                endcase
            end
        end
    end

    assign bus.sec         = sec_q;
    assign bus.minute_tick = mt_q;
    assign bus.hour_inc    = hi_q;
    assign bus.mode        = state;
    assign bus.blink       = blink_q;
endmodule
